// File: rtl/patch_dump_reader_if.sv
// Patch register bus plus SysEx byte stream seen by the dump reader.
// master = reader side, slave = responders / transmitter side.
interface patch_dump_reader_if #(
  parameter int BANKS = 4
);
  logic [6:0]       adr;
  logic             read;
  logic             sysex_data_patch_send;
  logic [BANKS-1:0] bank_sel;
  logic [7:0]       data_in;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (
    output adr,
    output read,
    output sysex_data_patch_send,
    output bank_sel,
    output tx_data,
    output tx_valid,
    input  data_in,
    input  tx_ready
  );

  modport slave (
    input  adr,
    input  read,
    input  sysex_data_patch_send,
    input  bank_sel,
    input  tx_data,
    input  tx_valid,
    output data_in,
    output tx_ready
  );
endinterface

// File: rtl/patch_dump_reader.sv
// Dumps one parameter bank as a nibblised SysEx stream.
// Define PATCH_DUMP_CHECKSUM_EN to append a 7-bit checksum before F7.
module patch_dump_reader #(
  parameter int         BANKS      = 4,
  parameter int         BANK_WIDTH = 2,
  parameter logic [6:0] ADR_FIRST  = 7'd0,
  parameter logic [6:0] ADR_LAST   = 7'd127,
  parameter logic [7:0] MFR_ID     = 8'h7D
) (
  input  logic                  sCLK_XVXENVS,
  input  logic                  reset_reg_N,
  input  logic                  start,
  input  logic [BANK_WIDTH-1:0] bank,
  output logic                  busy,
  output logic                  done,
  patch_dump_reader_if.master   bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_HDR2,
    S_SETADR,
    S_RDHI,
    S_RDLO,
    S_TXHI,
    S_TXLO,
`ifdef PATCH_DUMP_CHECKSUM_EN
    S_CKSUM,
`endif
    S_EOX,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [6:0]            adr_q, adr_d;
  logic [BANK_WIDTH-1:0] bank_q, bank_d;
  logic [7:0]            data_q, data_d;
  logic                  sel;
  logic                  hs;
  logic                  bank_ok;
`ifdef PATCH_DUMP_CHECKSUM_EN
  logic [6:0]            sum_q, sum_d;
`endif

  assign hs      = bus.tx_valid && bus.tx_ready;
  assign bank_ok = (32'(bank) < 32'(BANKS));
  assign bus.adr = adr_q;

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    bank_d    = bank_q;
    data_d    = data_q;
`ifdef PATCH_DUMP_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    sel          = 1'b0;
    done         = 1'b0;
    bus.read     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    unique case (state_q)
      S_IDLE: begin
        if (start && bank_ok) begin
          bank_d  = bank;
          adr_d   = ADR_FIRST;
`ifdef PATCH_DUMP_CHECKSUM_EN
          sum_d   = 7'd0;
`endif
          state_d = S_HDR0;
        end
      end
      S_HDR0: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hF0;
        if (hs) state_d = S_HDR1;
      end
      S_HDR1: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = MFR_ID;
        if (hs) state_d = S_HDR2;
      end
      S_HDR2: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'(bank_q);
        if (hs) state_d = S_SETADR;
      end
      S_SETADR: begin
        sel     = 1'b1;
        state_d = S_RDHI;
      end
      S_RDHI: begin
        sel      = 1'b1;
        bus.read = 1'b1;
        state_d  = S_RDLO;
      end
      S_RDLO: begin
        sel     = 1'b1;
        data_d  = bus.data_in;
        state_d = S_TXHI;
      end
      S_TXHI: begin
        sel          = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = {4'h0, data_q[7:4]};
        if (hs) begin
`ifdef PATCH_DUMP_CHECKSUM_EN
          sum_d   = sum_q + {3'b000, data_q[7:4]};
`endif
          state_d = S_TXLO;
        end
      end
      S_TXLO: begin
        sel          = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = {4'h0, data_q[3:0]};
        if (hs) begin
`ifdef PATCH_DUMP_CHECKSUM_EN
          sum_d = sum_q + {3'b000, data_q[3:0]};
`endif
          // test before increment so ADR_LAST=127 cannot wrap
          if (adr_q == ADR_LAST) begin
`ifdef PATCH_DUMP_CHECKSUM_EN
            state_d = S_CKSUM;
`else
            state_d = S_EOX;
`endif
          end else begin
            adr_d   = adr_q + 7'd1;
            state_d = S_SETADR;
          end
        end
      end
`ifdef PATCH_DUMP_CHECKSUM_EN
      S_CKSUM: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = {1'b0, 7'd0 - sum_q};
        if (hs) state_d = S_EOX;
      end
`endif
      S_EOX: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hF7;
        if (hs) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy = (state_q != S_IDLE) && (state_q != S_DONE);
    bus.sysex_data_patch_send = sel;
    bus.bank_sel = sel ? (BANKS'(1) << bank_q) : '0;
  end

  always_ff @(posedge sCLK_XVXENVS) begin
    if (!reset_reg_N) begin
      state_q <= S_IDLE;
      adr_q   <= 7'd0;
      bank_q  <= '0;
      data_q  <= 8'h00;
`ifdef PATCH_DUMP_CHECKSUM_EN
      sum_q   <= 7'd0;
`endif
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      bank_q  <= bank_d;
      data_q  <= data_d;
`ifdef PATCH_DUMP_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_patch_dump_reader.sv
// Bench for patch_dump_reader: single-address and full-range dumps.
// Expected streams include the checksum byte when PATCH_DUMP_CHECKSUM_EN is set.
module tb_patch_dump_reader;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [2:0] bank;
    bit         stall;
    logic [7:0] resp;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] ck;
    logic [3:0] sel;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_s = 1'b0;
  logic       start_f = 1'b0;
  logic [2:0] bank_s = 3'd0;
  logic [1:0] bank_f = 2'd0;
  logic       busy_s, done_s, busy_f, done_f;

  int n_chk = 0;
  int n_fail = 0;

  bit         stall_s = 1'b0;
  logic [7:0] resp_s = 8'hA5;
  int         cnt_s = 0;
  bq_t        q_s, q_f;
  logic [6:0] radr_f[$];
  int         rd_s, dn_s, stab_err, dn_f;
  logic [6:0] rd_adr_s;
  logic [3:0] rd_sel_s;
  bit         pv = 1'b0;
  bit         pr = 1'b0;
  logic [7:0] pd = 8'h00;

  patch_dump_reader_if #(.BANKS(4)) bs();
  patch_dump_reader_if #(.BANKS(4)) bf();

  patch_dump_reader #(
    .BANKS(4), .BANK_WIDTH(3), .ADR_FIRST(7'd6),
    .ADR_LAST(7'd6), .MFR_ID(8'h7D)
  ) u_s (
    .sCLK_XVXENVS(clk), .reset_reg_N(rst_n), .start(start_s),
    .bank(bank_s), .busy(busy_s), .done(done_s), .bus(bs)
  );

  patch_dump_reader u_f (
    .sCLK_XVXENVS(clk), .reset_reg_N(rst_n), .start(start_f),
    .bank(bank_f), .busy(busy_f), .done(done_f), .bus(bf)
  );

  always #5 clk = ~clk;

  always @(posedge bs.read)
    if (bs.sysex_data_patch_send && bs.bank_sel != 4'b0) bs.data_in <= resp_s;

  always @(posedge bf.read)
    bf.data_in <= {1'b0, bf.adr} ^ 8'h55;

  assign bf.tx_ready = 1'b1;

  always @(posedge clk) begin
    #1;
    bs.tx_ready = stall_s ? (cnt_s >= 5) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bs.tx_valid && bs.tx_ready) q_s.push_back(bs.tx_data);
      if (bs.read) begin
        rd_s++;
        rd_adr_s = bs.adr;
        rd_sel_s = bs.bank_sel;
      end
      if (done_s) dn_s++;
      if (pv && !pr && (!bs.tx_valid || bs.tx_data != pd)) stab_err++;
      if (bs.tx_valid && !bs.tx_ready) cnt_s++;
      else cnt_s = 0;
    end
    pv = rst_n && bs.tx_valid;
    pr = bs.tx_ready;
    pd = bs.tx_data;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bf.tx_valid && bf.tx_ready) q_f.push_back(bf.tx_data);
      if (bf.read) radr_f.push_back(bf.adr);
      if (done_f) dn_f++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_q(input string nm, input bq_t act, input bq_t exp);
    check({nm, "_len"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      check($sformatf("%s[%0d]", nm, i), act[i], exp[i]);
  endtask

  task automatic clr_s();
    q_s.delete();
    rd_s = 0;
    dn_s = 0;
    stab_err = 0;
  endtask

  task automatic pulse_s(input logic [2:0] b);
    @(posedge clk);
    #1;
    start_s = 1'b1;
    bank_s = b;
    @(posedge clk);
    #1;
    start_s = 1'b0;
  endtask

  task automatic wait_done_s(input string nm);
    int k;
    k = 0;
    while (dn_s == 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_done_seen"}, 32'(dn_s != 0), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  function automatic bq_t exp_small(input logic [2:0] b, input logic [7:0] hi,
                                    input logic [7:0] lo, input logic [7:0] ck);
    bq_t e;
    e.push_back(8'hF0);
    e.push_back(8'h7D);
    e.push_back({5'b0, b});
    e.push_back(hi);
    e.push_back(lo);
`ifdef PATCH_DUMP_CHECKSUM_EN
    e.push_back(ck);
`endif
    e.push_back(8'hF7);
    return e;
  endfunction

  vec_t tv[5];

  initial begin
    bq_t        e;
    logic [7:0] d;
    logic [6:0] sum;
    int         k;
    int         mism;

    tv[0] = '{3'd1, 1'b0, 8'hA5, 8'h0A, 8'h05, 8'h71, 4'b0010};
    tv[1] = '{3'd0, 1'b0, 8'h3C, 8'h03, 8'h0C, 8'h71, 4'b0001};
    tv[2] = '{3'd3, 1'b0, 8'hF1, 8'h0F, 8'h01, 8'h70, 4'b1000};
    tv[3] = '{3'd2, 1'b1, 8'h5E, 8'h05, 8'h0E, 8'h6D, 4'b0100};
    tv[4] = '{3'd1, 1'b1, 8'hA5, 8'h0A, 8'h05, 8'h71, 4'b0010};

    // reset with start held high
    clr_s();
    start_s = 1'b1;
    bank_s = 3'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy_s), 0);
    check("rst_tx_valid", 32'(bs.tx_valid), 0);
    check("rst_read", 32'(bs.read), 0);
    check("rst_bank_sel", 32'(bs.bank_sel), 0);
    check("rst_adr", 32'(bs.adr), 0);
    check("rst_tx_data", 32'(bs.tx_data), 0);
    check("rst_done", 32'(done_s), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    @(negedge clk);
    check("rel_busy", 32'(busy_s), 1);
    check("rel_tx_data", 32'(bs.tx_data), 32'h0F0);
    wait_done_s("rel");
    cmp_q("rel_stream", q_s, exp_small(3'd1, 8'h0A, 8'h05, 8'h71));

    // table-driven single-address dumps
    for (int i = 0; i < 5; i++) begin
      clr_s();
      stall_s = tv[i].stall;
      resp_s = tv[i].resp;
      pulse_s(tv[i].bank);
      wait_done_s($sformatf("v%0d", i));
      cmp_q($sformatf("v%0d_stream", i), q_s,
            exp_small(tv[i].bank, tv[i].hi, tv[i].lo, tv[i].ck));
      check($sformatf("v%0d_reads", i), rd_s, 1);
      check($sformatf("v%0d_read_adr", i), 32'(rd_adr_s), 6);
      check($sformatf("v%0d_sel", i), 32'(rd_sel_s), 32'(tv[i].sel));
      check($sformatf("v%0d_dones", i), dn_s, 1);
      check($sformatf("v%0d_stable", i), stab_err, 0);
      check($sformatf("v%0d_sel_idle", i), 32'(bs.bank_sel), 0);
      check($sformatf("v%0d_busy_idle", i), 32'(busy_s), 0);
    end
    stall_s = 1'b0;
    resp_s = 8'hA5;

    // out-of-range bank is ignored
    clr_s();
    pulse_s(3'd5);
    repeat (10) @(negedge clk);
    check("bad_bank_busy", 32'(busy_s), 0);
    check("bad_bank_stream", q_s.size(), 0);
    check("bad_bank_reads", rd_s, 0);

    // start while busy is ignored
    clr_s();
    pulse_s(3'd1);
    repeat (2) @(posedge clk);
    pulse_s(3'd3);
    @(negedge clk);
    check("busy_restart_busy", 32'(busy_s), 1);
    wait_done_s("busy_restart");
    cmp_q("busy_restart_stream", q_s, exp_small(3'd1, 8'h0A, 8'h05, 8'h71));
    check("busy_restart_reads", rd_s, 1);
    check("busy_restart_dones", dn_s, 1);
    check("busy_restart_idle", 32'(busy_s), 0);

    // reset during TXLO truncates the stream
    clr_s();
    stall_s = 1'b1;
    pulse_s(3'd1);
    k = 0;
    while (!(bs.tx_valid && q_s.size() >= 4) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("txlo_reached", 32'(bs.tx_data), 32'h05);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_tx_valid", 32'(bs.tx_valid), 0);
    check("midrst_busy", 32'(busy_s), 0);
    check("midrst_bank_sel", 32'(bs.bank_sel), 0);
    check("midrst_stream", q_s.size(), 4);
    repeat (3) @(negedge clk);
    check("midrst_done", dn_s, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stall_s = 1'b0;
    clr_s();
    pulse_s(3'd1);
    wait_done_s("fresh");
    cmp_q("fresh_stream", q_s, exp_small(3'd1, 8'h0A, 8'h05, 8'h71));

    // full 0..127 dump on the default-range instance
    q_f.delete();
    radr_f.delete();
    dn_f = 0;
    @(posedge clk);
    #1;
    start_f = 1'b1;
    bank_f = 2'd2;
    @(posedge clk);
    #1;
    start_f = 1'b0;
    k = 0;
    while (dn_f == 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("full_done_seen", 32'(dn_f != 0), 1);
    repeat (3) @(negedge clk);
    e.delete();
    e.push_back(8'hF0);
    e.push_back(8'h7D);
    e.push_back(8'h02);
    sum = 7'd0;
    for (int a = 0; a < 128; a++) begin
      d = 8'(a) ^ 8'h55;
      e.push_back({4'h0, d[7:4]});
      e.push_back({4'h0, d[3:0]});
      sum = sum + {3'b0, d[7:4]} + {3'b0, d[3:0]};
    end
`ifdef PATCH_DUMP_CHECKSUM_EN
    e.push_back({1'b0, 7'd0 - sum});
    check("full_len", q_f.size(), 261);
`else
    check("full_len", q_f.size(), 260);
`endif
    e.push_back(8'hF7);
    mism = 0;
    for (int i = 0; i < e.size() && i < q_f.size(); i++)
      if (q_f[i] !== e[i]) mism++;
    check("full_stream_mismatches", mism, 0);
    check("full_adr0_hi", 32'(q_f[3]), 32'h05);
    check("full_adr0_lo", 32'(q_f[4]), 32'h05);
    check("full_adr127_hi", 32'(q_f[257]), 32'h02);
    check("full_adr127_lo", 32'(q_f[258]), 32'h0A);
    check("full_last_f7", 32'(q_f[q_f.size()-1]), 32'hF7);
    check("full_reads", radr_f.size(), 128);
    mism = 0;
    for (int i = 0; i < radr_f.size(); i++)
      if (radr_f[i] != 7'(i)) mism++;
    check("full_read_order", mism, 0);
    check("full_dones", dn_f, 1);
    check("full_busy_idle", 32'(busy_f), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
